// File: rtl/sevenseg_scan_reader.sv
// Rebuilds BCD digits from a scanned seven-segment display bus. A digit is captured once per dwell
// after its pattern has been stable long enough; a full frame is handed out on a valid/ready port.
module sevenseg_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] out_bcd,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic { SETTLE, HELD } cap_state_t;
  typedef enum logic { EMPTY, FULL } out_state_t;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: return {1'b0, 4'd0};
      7'b0110000: return {1'b0, 4'd1};
      7'b1101101: return {1'b0, 4'd2};
      7'b1111001: return {1'b0, 4'd3};
      7'b0110011: return {1'b0, 4'd4};
      7'b1011011: return {1'b0, 4'd5};
      7'b1011111: return {1'b0, 4'd6};
      7'b1110000: return {1'b0, 4'd7};
      7'b1111111: return {1'b0, 4'd8};
      7'b1111011: return {1'b0, 4'd9};
      7'b0000000: return {1'b0, 4'hF};
      default:    return {1'b1, 4'hE};
    endcase
  endfunction

  logic [6:0]              samp_seg;
  logic [NUM_DIGITS-1:0]   samp_dig;
  logic [CW-1:0]           stab_cnt, stab_next;
  logic                    same;
  logic                    dig_onehot;
  logic [IW-1:0]           dig_idx;
  logic [3:0]              lut_bcd;
  logic                    lut_err;

  cap_state_t              cap_state, cap_next;
  logic                    capture;
  out_state_t              out_state, out_next;
  logic                    frame_complete, load, drop;

  logic [3:0]              slot_bcd [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   slot_err;
  logic [NUM_DIGITS-1:0]   captured, captured_next;
  logic [4*NUM_DIGITS-1:0] frame_bcd;

  assign same = ({dig_en, seg_in} == {samp_dig, samp_seg});

  // Capture and the counter reaching its limit share one edge, so the decision uses stab_next.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stab_next = '0;
    if (same) stab_next = (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + CW'(1);
  end

  assign {lut_err, lut_bcd} = decode(samp_seg);
  assign dig_onehot = (samp_dig != '0) && ((samp_dig & (samp_dig - NUM_DIGITS'(1))) == '0);

  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (samp_dig[i]) dig_idx = dig_idx | IW'(i);
  end

  always_comb begin
    cap_next = cap_state;
    capture  = 1'b0;
    case (cap_state)
      SETTLE: if (stab_next == STAB_MAX && dig_onehot) begin
        capture  = 1'b1;
        cap_next = HELD;
      end
      HELD: if (!same) cap_next = SETTLE;
    endcase
  end

  assign frame_complete = &captured;
  assign load = frame_complete && (out_state == EMPTY || out_ready);
  assign drop = frame_complete && out_state == FULL && !out_ready;

  always_comb begin
    out_next = out_state;
    if (load)                           out_next = FULL;
    else if (out_state == FULL && out_ready) out_next = EMPTY;
  end

  // A capture landing on the transfer edge belongs to the next frame.
  always_comb begin
    captured_next = frame_complete ? '0 : captured;
    if (capture) captured_next = captured_next | samp_dig;
  end

  always_comb begin
    frame_bcd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) frame_bcd[4*i +: 4] = slot_bcd[i];
  end

  assign out_valid = (out_state == FULL);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_seg  <= '0;
      samp_dig  <= '0;
      stab_cnt  <= '0;
      cap_state <= SETTLE;
      out_state <= EMPTY;
      captured  <= '0;
      slot_err  <= '0;
      out_bcd   <= '0;
      out_err   <= '0;
      overrun   <= 1'b0;
      // NOTE: the slot array is small and a partial frame must not leak past reset, so it is cleared.
      for (int i = 0; i < NUM_DIGITS; i++) slot_bcd[i] <= '0;
    end else begin
      samp_seg  <= seg_in;
      samp_dig  <= dig_en;
      stab_cnt  <= stab_next;
      cap_state <= cap_next;
      out_state <= out_next;
      captured  <= captured_next;
      if (capture) begin
        slot_bcd[dig_idx] <= lut_bcd;
        slot_err[dig_idx] <= lut_err;
      end
      if (load) begin
        out_bcd <= frame_bcd;
        out_err <= slot_err;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Scoreboard bench for sevenseg_scan_reader: expected frames are queued as digits are scanned and
// compared against frames the monitor sees accepted on the valid/ready port.
module tb_sevenseg_scan_reader;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] out_bcd;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int valid_cycles = 0;

  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  sevenseg_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_en    (dig_en),
    .out_bcd   (out_bcd),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample just before each rising edge, well after inputs change on the falling edge.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && out_valid) begin
      valid_cycles++;
      if (out_ready) got_q.push_back({out_err, out_bcd});
    end
  end

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    dig_en = d;
    seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input int n);
    hold(4'b0001, s0, n);
    hold(4'b0010, s1, n);
    hold(4'b0100, s2, n);
    hold(4'b1000, s3, n);
  endtask

  task automatic apply_reset();
    dig_en = '0;
    seg_in = '0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_bcd !== 16'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", out_bcd); end
    checks++; if (out_err !== 4'h0) begin failures++; $display("FAIL reset_err got=%b exp=0000", out_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_basic_frame();
    logic [19:0] e, g;
    out_ready = 1'b1;
    hold(4'b0001, seg_tab[1], 6);
    hold(4'b0010, seg_tab[2], 6);
    hold(4'b0100, seg_tab[3], 6);
    exp_q.push_back({4'b0000, 16'h4321});
    hold(4'b1000, seg_tab[4], 4);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency_valid got=%b exp=1", out_valid); end
    checks++; if (out_bcd !== 16'h4321) begin failures++; $display("FAIL basic_bcd got=%h exp=4321", out_bcd); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    hold(4'b0000, 7'b0, 10);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL basic_frame got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_short_dwell();
    int v0;
    v0 = valid_cycles;
    out_ready = 1'b1;
    repeat (2) scan4(seg_tab[1], seg_tab[2], seg_tab[3], seg_tab[4], 3);
    hold(4'b0000, 7'b0, 10);
    checks++; if (valid_cycles - v0 !== 0) begin failures++; $display("FAIL short_valid_cycles got=%0d exp=0", valid_cycles - v0); end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL short_frames got=%0d exp=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_illegal_blank();
    logic [19:0] e, g;
    out_ready = 1'b1;
    exp_q.push_back({4'b0100, 16'hFE21});
    scan4(seg_tab[1], seg_tab[2], 7'b1000000, 7'b0000000, 6);
    hold(4'b0000, 7'b0, 10);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL illegal_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL illegal_frame got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overrun();
    logic [19:0] e, g;
    out_ready = 1'b0;
    exp_q.push_back({4'b0000, 16'h8765});
    scan4(seg_tab[5], seg_tab[6], seg_tab[7], seg_tab[8], 6);
    hold(4'b0000, 7'b0, 2);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_a got=%b exp=1", out_valid); end
    checks++; if (out_bcd !== 16'h8765) begin failures++; $display("FAIL ovr_bcd_a got=%h exp=8765", out_bcd); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    scan4(seg_tab[9], seg_tab[0], seg_tab[1], seg_tab[2], 6);
    hold(4'b0000, 7'b0, 2);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_held got=%b exp=1", out_valid); end
    checks++; if (out_bcd !== 16'h8765) begin failures++; $display("FAIL ovr_bcd_held got=%h exp=8765", out_bcd); end
    checks++; if (out_err !== 4'b0000) begin failures++; $display("FAIL ovr_err_held got=%b exp=0000", out_err); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_handshake_valid got=%b exp=0", out_valid); end
    hold(4'b0000, 7'b0, 5);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_stays got=%b exp=1", overrun); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL ovr_frame got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [19:0] e, g;
    out_ready = 1'b1;
    hold(4'b0001, seg_tab[3], 6);
    hold(4'b0010, seg_tab[4], 6);
    dig_en = '0;
    seg_in = '0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", out_valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL mrst_overrun got=%b exp=0", overrun); end
    hold(4'b0100, seg_tab[5], 6);
    hold(4'b1000, seg_tab[6], 6);
    hold(4'b0000, 7'b0, 10);
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL mrst_partial got=%0d exp=0", got_q.size()); end
    exp_q.push_back({4'b0000, 16'h6521});
    scan4(seg_tab[1], seg_tab[2], seg_tab[5], seg_tab[6], 6);
    hold(4'b0000, 7'b0, 10);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL mrst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL mrst_frame got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_long_dwell();
    logic [19:0] e, g;
    apply_reset();
    out_ready = 1'b1;
    hold(4'b0011, seg_tab[8], 20);
    hold(4'b0000, seg_tab[8], 20);
    hold(4'b0010, seg_tab[7], 6);
    hold(4'b0100, seg_tab[3], 6);
    hold(4'b1000, seg_tab[0], 6);
    hold(4'b0000, 7'b0, 5);
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL long_bad_select got=%0d exp=0", got_q.size()); end
    exp_q.push_back({4'b0000, 16'h0379});
    hold(4'b0001, seg_tab[9], 50);
    hold(4'b0010, seg_tab[1], 6);
    hold(4'b0100, seg_tab[2], 6);
    hold(4'b1000, seg_tab[4], 6);
    hold(4'b0000, 7'b0, 5);
    checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL long_single_capture got=%0d exp=1", got_q.size()); end
    exp_q.push_back({4'b0000, 16'h4216});
    hold(4'b0001, seg_tab[6], 6);
    hold(4'b0000, 7'b0, 10);
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL long_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL long_frame got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    dig_en    = '0;
    seg_in    = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_short_dwell();
    test_illegal_blank();
    test_overrun();
    test_mid_reset();
    test_long_dwell();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
